// File: rtl/test_status_monitor_pkg.sv
// Shared definitions for the firmware self-test status monitor: channel state
// encoding and slice-indexing helper.
package test_status_monitor_pkg;

  localparam int unsigned StateWidth = 3;

  typedef enum logic [StateWidth-1:0] {
    StIdle    = 3'd0,
    StRunning = 3'd1,
    StPassed  = 3'd2,
    StFailed  = 3'd3,
    StTimeout = 3'd4
  } chan_state_e;

  // Low bit of channel idx inside a packed per-channel bus of the given width.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/test_channel_monitor.sv
// One self-test channel: input synchronisers, strobe edge detect, step counter,
// per-step watchdog and the IDLE/RUNNING/verdict state machine.
module test_channel_monitor
  import test_status_monitor_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH    = 8,
  parameter int unsigned TIMEOUT_WIDTH  = 24,
  parameter int unsigned TIMEOUT_CYCLES = 1500000,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned STRICT_MODE    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [COUNT_WIDTH-1:0] expected,
  input  logic                   success_async,
  input  logic                   next_async,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   done,
  output logic                   pass,
  output logic                   timed_out
);

  localparam int unsigned WdLast = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [TIMEOUT_WIDTH:0] WdLimit = (TIMEOUT_WIDTH + 1)'(WdLast);

  logic [SYNC_STAGES-1:0]   success_sync;
  logic [SYNC_STAGES-1:0]   next_sync;
  logic                     next_d1;
  logic [SYNC_STAGES:0]     primed;
  chan_state_e              state;
  logic [COUNT_WIDTH-1:0]   expected_q;
  logic [TIMEOUT_WIDTH-1:0] wdog;
  logic                     strobe;
  logic                     success_now;
  logic [COUNT_WIDTH-1:0]   count_inc;
  logic [TIMEOUT_WIDTH:0]   wdog_inc;

  // primed keeps a level held high through reset from looking like a fresh edge.
  assign strobe      = primed[SYNC_STAGES] & next_sync[SYNC_STAGES-1] & ~next_d1;
  assign success_now = success_sync[SYNC_STAGES-1];
  assign count_inc   = count + COUNT_WIDTH'(1);
  assign wdog_inc    = {1'b0, wdog} + (TIMEOUT_WIDTH + 1)'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      success_sync <= '0;
      next_sync    <= '0;
      next_d1      <= 1'b0;
      primed       <= '0;
    end else begin
      success_sync <= {success_sync[SYNC_STAGES-2:0], success_async};
      next_sync    <= {next_sync[SYNC_STAGES-2:0], next_async};
      next_d1      <= next_sync[SYNC_STAGES-1];
      primed       <= {primed[SYNC_STAGES-1:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      count      <= '0;
      wdog       <= '0;
      expected_q <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      timed_out  <= 1'b0;
    end else begin
      done      <= (state == StPassed) || (state == StFailed) || (state == StTimeout);
      pass      <= (state == StPassed);
      timed_out <= (state == StTimeout);
      if (!enable) begin
        state <= StIdle;
        count <= '0;
        wdog  <= '0;
      end else begin
        case (state)
          StIdle: begin
            expected_q <= expected;
            count      <= '0;
            wdog       <= '0;
            state      <= StRunning;
          end
          StRunning: begin
            if (expected_q == '0) begin
              state <= StPassed;
            end else if (strobe) begin
              // A strobe in the expiry cycle takes priority over the watchdog.
              count <= count_inc;
              wdog  <= '0;
              if (count_inc == expected_q) begin
                state <= success_now ? StPassed : StFailed;
              end else if ((STRICT_MODE != 0) && !success_now) begin
                state <= StFailed;
              end
            end else if (TIMEOUT_CYCLES != 0) begin
              wdog <= wdog_inc[TIMEOUT_WIDTH-1:0];
              if (wdog_inc >= WdLimit) begin
                state <= StTimeout;
              end
            end
          end
          StPassed, StFailed, StTimeout: begin
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: rtl/test_status_monitor.sv
// Multi-channel self-test monitor: one channel monitor per success/next pair plus
// registered all-done / all-pass reductions.
module test_status_monitor
  import test_status_monitor_pkg::*;
#(
  parameter int unsigned CHANNEL_COUNT  = 2,
  parameter int unsigned COUNT_WIDTH    = 8,
  parameter int unsigned TIMEOUT_WIDTH  = 24,
  parameter int unsigned TIMEOUT_CYCLES = 1500000,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned STRICT_MODE    = 0
) (
  input  logic                                 wb_clk_i,
  input  logic                                 wb_rst_i,
  input  logic                                 enable,
  input  logic [CHANNEL_COUNT*COUNT_WIDTH-1:0] expected_count,
  input  logic [CHANNEL_COUNT-1:0]             success_in,
  input  logic [CHANNEL_COUNT-1:0]             next_in,
  output logic [CHANNEL_COUNT*COUNT_WIDTH-1:0] test_count,
  output logic [CHANNEL_COUNT-1:0]             channel_done,
  output logic [CHANNEL_COUNT-1:0]             channel_pass,
  output logic [CHANNEL_COUNT-1:0]             channel_timeout,
  output logic                                 all_done,
  output logic                                 all_pass
);

  for (genvar g = 0; g < CHANNEL_COUNT; g++) begin : g_chan
    test_channel_monitor #(
      .COUNT_WIDTH   (COUNT_WIDTH),
      .TIMEOUT_WIDTH (TIMEOUT_WIDTH),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .SYNC_STAGES   (SYNC_STAGES),
      .STRICT_MODE   (STRICT_MODE)
    ) u_chan (
      .clk          (wb_clk_i),
      .rst          (wb_rst_i),
      .enable       (enable),
      .expected     (expected_count[slice_lo(g, COUNT_WIDTH) +: COUNT_WIDTH]),
      .success_async(success_in[g]),
      .next_async   (next_in[g]),
      .count        (test_count[slice_lo(g, COUNT_WIDTH) +: COUNT_WIDTH]),
      .done         (channel_done[g]),
      .pass         (channel_pass[g]),
      .timed_out    (channel_timeout[g])
    );
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      all_done <= 1'b0;
      all_pass <= 1'b0;
    end else begin
      all_done <= &channel_done;
      all_pass <= &channel_pass;
    end
  end

endmodule

// File: tb/tb_test_status_monitor.sv
// Bench for test_status_monitor: a non-strict and a strict instance share random and
// directed stimulus and are checked every cycle against a behavioural channel model.
module tb_test_status_monitor;

  localparam int CC = 4;
  localparam int CW = 8;
  localparam int TW = 24;
  localparam int TC = 100;
  localparam int SS = 2;

  localparam int MIdle = 0, MRun = 1, MPass = 2, MFail = 3, MTout = 4;

  logic clk;
  logic rst;
  logic en;
  logic [CC*CW-1:0] expc;
  logic [CC-1:0] succ;
  logic [CC-1:0] nxt;

  logic [CC*CW-1:0] cnt0, cnt1;
  logic [CC-1:0] done0, pass0, tout0, done1, pass1, tout1;
  logic ad0, ap0, ad1, ap1;

  int n_checks = 0;
  int n_fail = 0;

  int  mt = 0;
  int  since = 0;
  bit  nh [CC][SS+2];
  bit  sh [CC][SS+2];
  int  m_st [2][CC];
  int  m_cnt [2][CC];
  int  m_exp [2][CC];
  int  m_last [2][CC];
  bit  m_done [2][CC];
  bit  m_pass [2][CC];
  bit  m_tout [2][CC];
  bit  m_ad [2];
  bit  m_ap [2];

  test_status_monitor #(
    .CHANNEL_COUNT(CC), .COUNT_WIDTH(CW), .TIMEOUT_WIDTH(TW),
    .TIMEOUT_CYCLES(TC), .SYNC_STAGES(SS), .STRICT_MODE(0)
  ) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .enable(en), .expected_count(expc),
    .success_in(succ), .next_in(nxt), .test_count(cnt0), .channel_done(done0),
    .channel_pass(pass0), .channel_timeout(tout0), .all_done(ad0), .all_pass(ap0)
  );

  test_status_monitor #(
    .CHANNEL_COUNT(CC), .COUNT_WIDTH(CW), .TIMEOUT_WIDTH(TW),
    .TIMEOUT_CYCLES(TC), .SYNC_STAGES(SS), .STRICT_MODE(1)
  ) u_dut_strict (
    .wb_clk_i(clk), .wb_rst_i(rst), .enable(en), .expected_count(expc),
    .success_in(succ), .next_in(nxt), .test_count(cnt1), .channel_done(done1),
    .channel_pass(pass1), .channel_timeout(tout1), .all_done(ad1), .all_pass(ap1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, mt, got, exp);
    end
  endtask

  // One clock edge of the reference: every strobe reaches the channel SS+1 edges
  // after it was driven, and verdict flags trail the channel state by one edge.
  task automatic model_step();
    bit ev, s, alld, allp;
    mt++;
    for (int c = 0; c < CC; c++) begin
      for (int a = SS + 1; a > 0; a--) begin
        nh[c][a] = nh[c][a-1];
        sh[c][a] = sh[c][a-1];
      end
      nh[c][0] = rst ? 1'b0 : nxt[c];
      sh[c][0] = rst ? 1'b0 : succ[c];
    end
    since = rst ? 0 : since + 1;
    for (int i = 0; i < 2; i++) begin
      alld = 1'b1;
      allp = 1'b1;
      for (int c = 0; c < CC; c++) begin
        alld &= m_done[i][c];
        allp &= m_pass[i][c];
      end
      m_ad[i] = !rst && alld;
      m_ap[i] = !rst && allp;
      for (int c = 0; c < CC; c++) begin
        m_done[i][c] = !rst && (m_st[i][c] >= MPass);
        m_pass[i][c] = !rst && (m_st[i][c] == MPass);
        m_tout[i][c] = !rst && (m_st[i][c] == MTout);
        ev = (since >= SS + 2) && nh[c][SS] && !nh[c][SS+1];
        s  = sh[c][SS];
        if (rst || !en) begin
          m_st[i][c]  = MIdle;
          m_cnt[i][c] = 0;
        end else if (m_st[i][c] == MIdle) begin
          m_exp[i][c]  = int'(expc[c*CW +: CW]);
          m_st[i][c]   = MRun;
          m_last[i][c] = mt;
        end else if (m_st[i][c] == MRun) begin
          if (m_exp[i][c] == 0) begin
            m_st[i][c] = MPass;
          end else if (ev) begin
            m_cnt[i][c]++;
            m_last[i][c] = mt;
            if (m_cnt[i][c] == m_exp[i][c]) m_st[i][c] = s ? MPass : MFail;
            else if (i == 1 && !s) m_st[i][c] = MFail;
          end else if (mt - m_last[i][c] >= TC - 1) begin
            m_st[i][c] = MTout;
          end
        end
      end
    end
  endtask

  task automatic compare();
    logic [CW-1:0] gc;
    logic gd, gp, gt;
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < CC; c++) begin
        gc = (i == 0) ? cnt0[c*CW +: CW] : cnt1[c*CW +: CW];
        gd = (i == 0) ? done0[c] : done1[c];
        gp = (i == 0) ? pass0[c] : pass1[c];
        gt = (i == 0) ? tout0[c] : tout1[c];
        check($sformatf("inst%0d ch%0d test_count", i, c), gc, m_cnt[i][c]);
        check($sformatf("inst%0d ch%0d channel_done", i, c), gd, m_done[i][c]);
        check($sformatf("inst%0d ch%0d channel_pass", i, c), gp, m_pass[i][c]);
        check($sformatf("inst%0d ch%0d channel_timeout", i, c), gt, m_tout[i][c]);
      end
      check($sformatf("inst%0d all_done", i), (i == 0) ? ad0 : ad1, m_ad[i]);
      check($sformatf("inst%0d all_pass", i), (i == 0) ? ap0 : ap1, m_ap[i]);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (mt < target) step();
  endtask

  task automatic pulse(input logic [CC-1:0] mask);
    nxt = nxt | mask;
    repeat (3) step();
    nxt = nxt & ~mask;
    repeat (3) step();
  endtask

  task automatic rearm(input logic [CC*CW-1:0] e);
    en = 1'b0;
    repeat (3) step();
    expc = e;
    en = 1'b1;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int p, k;
    rst = 1'b1; en = 1'b0; expc = '0; succ = '0; nxt = '1;
    repeat (4) step();
    rst = 1'b0;
    repeat (8) step();
    check("reset test_count", cnt0, 0);
    check("reset channel_done", done0, 0);
    check("reset all_done", ad0, 0);
    nxt = '0;
    repeat (4) step();

    // Basic pass: ch0 expects 3 strobes ten cycles apart, ch1/ch3 one, ch2 zero.
    succ = '1;
    rearm({8'd1, 8'd0, 8'd1, 8'd3});
    pulse(4'b1010);
    pulse(4'b0001);
    repeat (4) step();
    pulse(4'b0001);
    repeat (4) step();
    nxt[0] = 1'b1;
    p = mt;
    wait_until(p + 3);
    nxt[0] = 1'b0;
    check("basic count", cnt0[CW-1:0], 3);
    check("basic pass early", pass0[0], 0);
    wait_until(p + 4);
    check("basic pass", pass0[0], 1);
    check("basic all_pass early", ap0, 0);
    wait_until(p + 5);
    check("basic all_pass", ap0, 1);
    repeat (4) step();

    // Final-step failure, and strict-mode failure on an intermediate step.
    rearm({8'd0, 8'd0, 8'd2, 8'd2});
    succ = 4'b1101;
    pulse(4'b0011);
    succ = 4'b1110;
    pulse(4'b0011);
    repeat (4) step();
    check("final fail done", done0[0], 1);
    check("final fail pass", pass0[0], 0);
    check("final fail count", cnt0[CW-1:0], 2);
    check("late pass ch1", pass0[1], 1);
    check("strict fail done", done1[1], 1);
    check("strict fail pass", pass1[1], 0);
    check("strict fail count", cnt1[2*CW-1:CW], 1);

    // Watchdog: ch0 goes silent, ch1 strobes exactly in its expiry cycle.
    succ = '1;
    rearm({8'd1, 8'd0, 8'd4, 8'd4});
    nxt = 4'b0011;
    p = mt;
    k = p + SS + 1;
    wait_until(k);
    nxt = '0;
    check("timeout first count", cnt0[CW-1:0], 1);
    wait_until(p + TC - 1);
    nxt[1] = 1'b1;
    wait_until(k + TC - 1);
    nxt[1] = 1'b0;
    check("timeout early", tout0[0], 0);
    wait_until(k + TC);
    check("timeout flag", tout0[0], 1);
    check("timeout count", cnt0[CW-1:0], 1);
    check("expiry strobe no timeout", tout0[1], 0);
    check("expiry strobe count", cnt0[2*CW-1:CW], 2);
    wait_until(p + 2 * TC + 6);
    check("multi all_done", ad0, 1);
    check("multi all_pass", ap0, 0);

    // Abort mid-run and re-arm, then reset with next held high.
    rearm({8'd5, 8'd5, 8'd5, 8'd5});
    pulse(4'b0001);
    pulse(4'b0001);
    check("abort pre count", cnt0[CW-1:0], 2);
    en = 1'b0;
    repeat (2) step();
    check("abort count cleared", cnt0, 0);
    check("abort done cleared", done0, 0);
    en = 1'b1;
    step();
    pulse(4'b0001);
    check("rearm count", cnt0[CW-1:0], 1);
    nxt = '1;
    step();
    rst = 1'b1;
    step();
    check("reset mid-run count", cnt0, 0);
    repeat (2) step();
    rst = 1'b0;
    repeat (10) step();
    check("held next no count", cnt0, 0);
    nxt = '0;
    repeat (4) step();

    for (int n = 0; n < 4000; n++) begin
      for (int c = 0; c < CC; c++) begin
        if (((n / 200) % 3 != 2) && ($urandom_range(7) == 0)) nxt[c] = ~nxt[c];
        if ($urandom_range(3) == 0) succ[c] = ($urandom_range(4) != 0);
        if ($urandom_range(49) == 0) expc[c*CW +: CW] = CW'($urandom_range(4));
      end
      if (en) en = ($urandom_range(299) != 0);
      else en = ($urandom_range(9) == 0);
      rst = ($urandom_range(999) == 0);
      step();
    end
    rst = 1'b0;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
